// File: rtl/jag_pad_pkg.sv
// Shared types and constants for the Jaguar joypad scanner.
// Button bit positions, the scanner state encoding and the matrix-to-button
// decode used by jag_pad_scanner (and jag_pad_debounce when
// JAG_PAD_DEBOUNCE_EN is defined).
package jag_pad_pkg;

  localparam int BTN_W = 21;

  localparam int BTN_PAUSE  = 0;
  localparam int BTN_A      = 1;
  localparam int BTN_B      = 2;
  localparam int BTN_C      = 3;
  localparam int BTN_OPTION = 4;
  localparam int BTN_RIGHT  = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_DOWN   = 7;
  localparam int BTN_UP     = 8;
  localparam int BTN_KEY0   = 9;
  localparam int BTN_STAR   = 19;
  localparam int BTN_HASH   = 20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    GAP     = 2'd2,
    PUBLISH = 2'd3
  } state_t;

  // Active-high row samples, index 0 = col1 ... 3 = col4, rows numbered 6..1.
  typedef logic [3:0][6:1] matrix_t;

  // Map the four captured columns onto the button word. Row1 only carries
  // pause (col4); on col1..col3 it is left unconnected.
  function automatic logic [BTN_W-1:0] decode_matrix(input matrix_t pr);
    logic [BTN_W-1:0] b;
    b = '0;
    b[BTN_OPTION]   = pr[0][2];
    b[BTN_KEY0 + 3] = pr[0][3];
    b[BTN_KEY0 + 6] = pr[0][4];
    b[BTN_KEY0 + 9] = pr[0][5];
    b[BTN_HASH]     = pr[0][6];
    b[BTN_C]        = pr[1][2];
    b[BTN_KEY0 + 2] = pr[1][3];
    b[BTN_KEY0 + 5] = pr[1][4];
    b[BTN_KEY0 + 8] = pr[1][5];
    b[BTN_KEY0]     = pr[1][6];
    b[BTN_B]        = pr[2][2];
    b[BTN_KEY0 + 1] = pr[2][3];
    b[BTN_KEY0 + 4] = pr[2][4];
    b[BTN_KEY0 + 7] = pr[2][5];
    b[BTN_STAR]     = pr[2][6];
    b[BTN_PAUSE]    = pr[3][1];
    b[BTN_A]        = pr[3][2];
    b[BTN_RIGHT]    = pr[3][3];
    b[BTN_LEFT]     = pr[3][4];
    b[BTN_DOWN]     = pr[3][5];
    b[BTN_UP]       = pr[3][6];
    return b;
  endfunction

endpackage

// File: rtl/jag_pad_debounce.sv
// Snapshot debouncer for the joypad scanner (used when JAG_PAD_DEBOUNCE_EN
// is defined). Keeps the previous DB_COUNT-1 snapshots; together with the
// incoming one that is a DB_COUNT-deep window. update is raised on a strobe
// when every snapshot in that window is identical.
module jag_pad_debounce
  import jag_pad_pkg::*;
#(
  parameter int unsigned DB_COUNT = 3
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [BTN_W-1:0] snapshot,
  input  logic             strobe,
  output logic [BTN_W-1:0] stable,
  output logic             update
);

  localparam int unsigned HIST = DB_COUNT - 1;

  logic [HIST-1:0][BTN_W-1:0] hist_q;
  logic                       all_same;

  // Incoming snapshot must match every stored one.
  always_comb begin
    all_same = 1'b1;
    for (int i = 0; i < int'(HIST); i++) begin
      if (hist_q[i] != snapshot) all_same = 1'b0;
    end
  end

  assign stable = snapshot;
  assign update = strobe & all_same;

  // Shift the history once per completed scan.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      hist_q <= '0;
    end else if (strobe) begin
      hist_q[0] <= snapshot;
      for (int i = 1; i < int'(HIST); i++) begin
        hist_q[i] <= hist_q[i-1];
      end
    end
  end

endmodule

// File: rtl/jag_pad_scanner.sv
// Autonomous Jaguar joypad matrix scanner.
// Walks col1..col4 low one at a time, samples the active-low rows at the end
// of each settle window, and publishes a 21-bit active-high button word once
// per scan. Define JAG_PAD_DEBOUNCE_EN to gate button updates through
// jag_pad_debounce; otherwise every scan loads the raw snapshot.
//
// state   | meaning
// IDLE    | all columns high, counting SCAN_GAP cycles (held while enable=0)
// DRIVE   | selected column low for SETTLE cycles, rows captured on the last
// GAP     | one cycle all columns high before the next column
// PUBLISH | one cycle, raw snapshot handed to the output stage
module jag_pad_scanner
  import jag_pad_pkg::*;
#(
  parameter int unsigned SETTLE   = 16,
  parameter int unsigned SCAN_GAP = 1024,
  parameter int unsigned DB_COUNT = 3
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [6:1]       row_n,
  output logic [4:1]       col_n,
  output logic [BTN_W-1:0] buttons,
  output logic             buttons_valid,
  output logic             changed
);

  localparam int unsigned CNT_MAX = (SCAN_GAP > SETTLE) ? SCAN_GAP : SETTLE;
  localparam int          CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(SCAN_GAP - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [1:0]       col_q, col_nxt;
  matrix_t          rows_q;
  logic             capture, publish, abort;
  logic [BTN_W-1:0] raw;
  logic [BTN_W-1:0] new_word;
  logic             load;

  // Next-state, counter and column-index logic; enable low overrides all.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    col_nxt   = col_q;
    capture   = 1'b0;
    publish   = 1'b0;
    abort     = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      col_nxt   = '0;
      abort     = (state_q != IDLE);
    end else begin
      case (state_q)
        IDLE: begin
          if (cnt_q == GAP_LAST) begin
            state_nxt = DRIVE;
            cnt_nxt   = '0;
            col_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_q == SETTLE_LAST) begin
            capture   = 1'b1;
            state_nxt = GAP;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (col_q == 2'd3) begin
            state_nxt = PUBLISH;
          end else begin
            state_nxt = DRIVE;
            col_nxt   = col_q + 2'd1;
          end
        end
        PUBLISH: begin
          publish   = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
          col_nxt   = '0;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          col_nxt   = '0;
        end
      endcase
    end
  end

  // State, counters, registered column drive and row capture.
  // col_n is decoded from the next state so it changes on the same edge as
  // the FSM and reaches the pads without decode glitches.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
      col_n   <= 4'b1111;
      rows_q  <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      col_q   <= col_nxt;
      col_n   <= (state_nxt == DRIVE) ? ~(4'b0001 << col_nxt) : 4'b1111;
      if (capture) begin
        rows_q[col_q] <= ~row_n;
      end else if (abort) begin
        rows_q <= '0;
      end
    end
  end

  assign raw = decode_matrix(rows_q);

`ifdef JAG_PAD_DEBOUNCE_EN
  jag_pad_debounce #(
    .DB_COUNT (DB_COUNT)
  ) u_debounce (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .snapshot (raw),
    .strobe   (publish),
    .stable   (new_word),
    .update   (load)
  );
`else
  assign new_word = raw;
  assign load     = publish;
`endif

  // Output stage: registered word, scan-complete pulse and change pulse.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      buttons       <= '0;
      buttons_valid <= 1'b0;
      changed       <= 1'b0;
    end else begin
      buttons_valid <= publish;
      changed       <= load && (new_word != buttons);
      if (load) buttons <= new_word;
    end
  end

endmodule

// File: tb/tb_jag_pad_scanner.sv
// Directed bench for jag_pad_scanner with SETTLE=4, SCAN_GAP=8, DB_COUNT=3.
// A behavioural joypad matrix drives row_n from col_n and a pressed-button
// vector. Expectations adapt when JAG_PAD_DEBOUNCE_EN is defined.
module tb_jag_pad_scanner;

  localparam int SETTLE   = 4;
  localparam int SCAN_GAP = 8;
  localparam int DB_COUNT = 3;
  localparam int PERIOD   = SCAN_GAP + 4 * (SETTLE + 1) + 1;
`ifdef JAG_PAD_DEBOUNCE_EN
  localparam int NSCAN = 3;
`else
  localparam int NSCAN = 1;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable  = 1'b0;
  logic [6:1]  row_n;
  logic [4:1]  col_n;
  logic [20:0] buttons;
  logic        buttons_valid;
  logic        changed;

  logic [20:0] press = '0;
  logic        noise = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk_sys = ~clk_sys;

  jag_pad_scanner #(
    .SETTLE   (SETTLE),
    .SCAN_GAP (SCAN_GAP),
    .DB_COUNT (DB_COUNT)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .enable        (enable),
    .row_n         (row_n),
    .col_n         (col_n),
    .buttons       (buttons),
    .buttons_valid (buttons_valid),
    .changed       (changed)
  );

  // Joypad matrix: a pressed button pulls its row low while its column is low.
  always_comb begin
    row_n = 6'h3F;
    case (col_n)
      4'b1110: begin
        row_n[1] = ~noise;
        row_n[2] = ~press[4];
        row_n[3] = ~press[12];
        row_n[4] = ~press[15];
        row_n[5] = ~press[18];
        row_n[6] = ~press[20];
      end
      4'b1101: begin
        row_n[1] = ~noise;
        row_n[2] = ~press[3];
        row_n[3] = ~press[11];
        row_n[4] = ~press[14];
        row_n[5] = ~press[17];
        row_n[6] = ~press[9];
      end
      4'b1011: begin
        row_n[1] = ~noise;
        row_n[2] = ~press[2];
        row_n[3] = ~press[10];
        row_n[4] = ~press[13];
        row_n[5] = ~press[16];
        row_n[6] = ~press[19];
      end
      4'b0111: begin
        row_n[1] = ~press[0];
        row_n[2] = ~press[1];
        row_n[3] = ~press[5];
        row_n[4] = ~press[6];
        row_n[5] = ~press[7];
        row_n[6] = ~press[8];
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_valid(input int limit);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (buttons_valid !== 1'b1 && n < limit);
    check("valid_seen", {31'd0, buttons_valid}, 32'd1);
  endtask

  // Expected col_n after edge k counted from reset release.
  function automatic logic [4:1] exp_col(input int k);
    int off;
    logic [4:1] one;
    one = 4'b0001;
    if (k < SCAN_GAP) return 4'b1111;
    off = (k - SCAN_GAP) % PERIOD;
    if (off >= 4 * (SETTLE + 1)) return 4'b1111;
    if ((off % (SETTLE + 1)) == SETTLE) return 4'b1111;
    return ~(one << (off / (SETTLE + 1)));
  endfunction

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [20:0] held;
    int          seen;

    // Reset values
    reset_n = 1'b0;
    enable  = 1'b1;
    repeat (3) tick();
    check("rst_col_n",   {28'd0, col_n}, 32'hF);
    check("rst_buttons", {11'd0, buttons}, 32'd0);
    check("rst_valid",   {31'd0, buttons_valid}, 32'd0);
    check("rst_changed", {31'd0, changed}, 32'd0);

    // Two idle scans: column sequence, settle length and valid timing
    reset_n = 1'b1;
    for (int k = 1; k <= 2 * PERIOD; k++) begin
      tick();
      check("scan_col_n", {28'd0, col_n}, {28'd0, exp_col(k)});
      check("scan_valid", {31'd0, buttons_valid}, {31'd0, (k == PERIOD || k == 2 * PERIOD)});
      if (k == PERIOD) begin
        check("idle_buttons", {11'd0, buttons}, 32'd0);
        check("idle_changed", {31'd0, changed}, 32'd0);
      end
    end

    // a + key5
    press = 21'h004002;
    repeat (NSCAN) wait_valid(100);
    check("a_key5_buttons", {11'd0, buttons}, 32'h004002);
    check("a_key5_changed", {31'd0, changed}, 32'd1);
    tick();
    check("changed_pulse", {31'd0, changed}, 32'd0);
    check("valid_pulse",   {31'd0, buttons_valid}, 32'd0);
    wait_valid(100);
    check("a_key5_hold",      {11'd0, buttons}, 32'h004002);
    check("a_key5_unchanged", {31'd0, changed}, 32'd0);

    // hash + pause, with row1 noise on col1..col3
    press = 21'h100001;
    noise = 1'b1;
    repeat (NSCAN) wait_valid(100);
    check("hash_pause_buttons", {11'd0, buttons}, 32'h100001);
    check("hash_pause_changed", {31'd0, changed}, 32'd1);
    noise = 1'b0;

    // up toggling every scan
`ifdef JAG_PAD_DEBOUNCE_EN
    for (int i = 0; i < 4; i++) begin
      press = (i % 2 == 0) ? 21'h000100 : 21'h000000;
      wait_valid(100);
      check("toggle_buttons", {11'd0, buttons}, 32'h100001);
    end
    press = 21'h000100;
    wait_valid(100);
    check("up_hold1", {31'd0, buttons[8]}, 32'd0);
    wait_valid(100);
    check("up_hold2", {31'd0, buttons[8]}, 32'd0);
    wait_valid(100);
    check("up_hold3",   {11'd0, buttons}, 32'h000100);
    check("up_changed", {31'd0, changed}, 32'd1);
    held = 21'h000100;
`else
    for (int i = 0; i < 4; i++) begin
      press = (i % 2 == 0) ? 21'h000100 : 21'h000000;
      wait_valid(100);
      check("toggle_buttons", {11'd0, buttons}, {11'd0, press});
      check("toggle_changed", {31'd0, changed}, 32'd1);
    end
    held = 21'h000000;
`endif

    // enable dropped during col3 DRIVE
    press = 21'h000010;
    repeat (SCAN_GAP + 2 * (SETTLE + 1) + 1) tick();
    check("en_col3_low", {28'd0, col_n}, 32'hB);
    enable = 1'b0;
    tick();
    check("en_release", {28'd0, col_n}, 32'hF);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (buttons_valid === 1'b1) seen++;
      tick();
    end
    check("en_no_valid", seen, 0);
    check("en_buttons_held", {11'd0, buttons}, {11'd0, held});
    enable = 1'b1;
    repeat (SCAN_GAP - 1) tick();
    check("rescan_idle", {28'd0, col_n}, 32'hF);
    tick();
    check("rescan_col1", {28'd0, col_n}, 32'hE);
    repeat (NSCAN) wait_valid(100);
    check("rescan_buttons", {11'd0, buttons}, 32'h000010);

    // reset during col2 DRIVE
    repeat (SCAN_GAP + (SETTLE + 1) + 1) tick();
    check("rst_col2_low", {28'd0, col_n}, 32'hD);
    reset_n = 1'b0;
    tick();
    check("midrst_col_n",   {28'd0, col_n}, 32'hF);
    check("midrst_buttons", {11'd0, buttons}, 32'd0);
    check("midrst_valid",   {31'd0, buttons_valid}, 32'd0);
    reset_n = 1'b1;
    repeat (SCAN_GAP - 1) tick();
    check("post_rst_idle", {28'd0, col_n}, 32'hF);
    tick();
    check("post_rst_col1", {28'd0, col_n}, 32'hE);
    repeat (NSCAN) wait_valid(100);
    check("post_rst_buttons", {11'd0, buttons}, 32'h000010);
    check("post_rst_changed", {31'd0, changed}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jag_pad_scanner.md
# jag_pad_scanner

Autonomous scanner for the Jaguar joypad matrix. Drives the four active-low column selects one at a time, waits for the row lines to settle, and samples the six active-low row returns. Assembles a 21-bit active-high button snapshot once per full scan. Sits between the controller matrix (or its emulation) and the core's input registers, so the rest of the core reads a stable, optionally debounced button word instead of sequencing columns itself.

## Interface
- SETTLE, 16: cycles a column is held low before its rows are sampled (≥1).
- SCAN_GAP, 1024: idle cycles with all columns high between scans (≥1).
- DB_COUNT, 3: consecutive identical snapshots required before `buttons` updates (≥2; used only with debounce).
- clk_sys  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  scanning permitted; low forces idle.
- row_n  in  6 [6:1]  matrix row returns, active-low.
- col_n  out  4 [4:1]  matrix column selects, active-low, at most one low.
- buttons  out  21  debounced/raw button state, active-high.
- buttons_valid  out  1  one-cycle pulse per completed scan.
- changed  out  1  one-cycle pulse, coincident with buttons_valid, when `buttons` took a new value.

## Operation
- Bit order of `buttons`:
  - [0] pause, [1] a, [2] b, [3] c, [4] option
  - [5] right, [6] left, [7] down, [8] up
  - [9+n] key n for n = 0..9
  - [19] star, [20] hash
- Row mapping, pressed = row low:
  - col1: row2 option, row3 3, row4 6, row5 9, row6 hash.
  - col2: row2 c, row3 2, row4 5, row5 8, row6 0.
  - col3: row2 b, row3 1, row4 4, row5 7, row6 star.
  - col4: row1 pause, row2 a, row3 right, row4 left, row5 down, row6 up.
  - row1 is ignored on col1–col3.
- States:
  - IDLE: col_n=4'b1111; count SCAN_GAP cycles, then go to DRIVE with column index 1. Remain in IDLE while enable=0.
  - DRIVE: the selected column is low for SETTLE cycles. On the last cycle, row_n is captured into the raw snapshot register.
  - GAP: one cycle with col_n=4'b1111 (break-before-make). Then DRIVE the next column, or go to PUBLISH after col4.
  - PUBLISH: one cycle. Raw snapshot is presented to the output stage, buttons_valid pulses, then return to IDLE.
- If enable drops in any state, the next state is IDLE, col_n=1111 on the following cycle, the partial snapshot is discarded, and no buttons_valid pulse occurs. The idle counter restarts.
- The column index wraps only through PUBLISH; it is never reused mid-scan.

## Timing
- Reset values:
  - col_n=4'b1111, buttons=0, buttons_valid=0, changed=0
  - state IDLE, counters 0, debounce history 0
- Reset mid-scan: column released on the first clock with reset_n low.
- Per scan: 4·(SETTLE+1)+1 cycles active, then SCAN_GAP cycles idle.
- buttons, buttons_valid and changed are registered. They update on the clock edge ending PUBLISH, so they are visible the cycle after PUBLISH.
- First buttons_valid after reset with enable=1: cycle SCAN_GAP + 4·(SETTLE+1) + 1.

## Configuration
- JAG_PAD_DEBOUNCE_EN defined:
  - A DB_COUNT-deep history of raw snapshots is kept.
  - buttons loads the raw snapshot only when the last DB_COUNT snapshots are identical; otherwise it holds.
  - buttons_valid still pulses on every completed scan.
- JAG_PAD_DEBOUNCE_EN undefined:
  - buttons loads the raw snapshot every PUBLISH.
  - DB_COUNT is unused.
  - changed = (raw ≠ previous buttons).

## Structure
- Package jag_pad_pkg holds:
  - state enum (IDLE, DRIVE, GAP, PUBLISH)
  - button bit-index localparams (BTN_PAUSE … BTN_HASH)
  - BTN_W = 21
- Sub-module jag_pad_debounce: history shift register and equality compare.
  - Instantiated only under JAG_PAD_DEBOUNCE_EN.
  - Inputs: snapshot and strobe. Outputs: stable word and update flag.

## Test plan
- SETTLE=4, SCAN_GAP=8, no buttons pressed → col_n sequence 1110,1111,1101,1111,1011,1111,0111,1111 with each low phase exactly 4 cycles; first buttons_valid at cycle 29; buttons=0; changed=0.
- Matrix model with a pressed and key 5 held → buttons=21'h004002; changed pulses once, then stays 0 on subsequent scans.
- Hash pressed only while col1 low, pause only while col4 low → buttons bit20 and bit0 set; row1 noise on col2 is ignored.
- Debounce on, DB_COUNT=3; up toggles every scan → buttons bit8 never changes. Up held for 3 scans → bit8 sets on the third buttons_valid.
- enable dropped during col3 DRIVE → col_n=1111 next cycle, no buttons_valid pulse, buttons unchanged; rescan after SCAN_GAP.
- reset_n low during col2 DRIVE → col_n=1111 and buttons=0 on the next edge; after release, full scan restarts from IDLE.
